// File: rtl/time_keeper.sv
// Day-of-week clock: a free-running sub-second counter drives sec/min/hour/day,
// with a mode/up button pair for setting hour, minute and day in place.

module time_keeper_deb #(
    parameter int DEB_CYCLES = 270000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_p
);
    localparam int DW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] RUN_LIM = DW'(DEB_CYCLES);

    logic          sync1_q, sync2_q, last_q, prev_q;
    logic          stable_q, stable_d;
    logic          armed_q, armed_d;
    logic [1:0]    settle_q, settle_d;
    logic [DW-1:0] run_q, run_d;

    // The first two synchronizer outputs after reset are reset values, not samples.
    // A press is only armed once a released (low) level has been accepted, so a
    // button held through reset stays silent until released and pressed again.
    always_comb begin
        settle_d = settle_q;
        run_d    = run_q;
        stable_d = stable_q;
        armed_d  = armed_q;
        if (settle_q != 2'd2) begin
            settle_d = settle_q + 2'd1;
            run_d    = '0;
        end else begin
            if (sync2_q != last_q) begin
                run_d = DW'(1);
            end else if (run_q != RUN_LIM) begin
                run_d = run_q + DW'(1);
            end
            if (run_d == RUN_LIM) begin
                stable_d = sync2_q;
                if (!sync2_q) begin
                    armed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            last_q   <= 1'b0;
            prev_q   <= 1'b0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
            run_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            prev_q   <= stable_q;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
            run_q    <= run_d;
        end
    end

    assign press_p = stable_q & ~prev_q & armed_q;
endmodule

// state    | meaning
// RUN      | clock counting, buttons other than mode ignored
// SET_HOUR | counting frozen, up increments hour
// SET_MIN  | counting frozen, up increments minute
// SET_DAY  | counting frozen, up increments day; leaving clears cnt and sec
module time_keeper #(
    parameter int CNT_MAX    = 5399999,
    parameter int DEB_CYCLES = 270000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    output logic [27:0] cnt,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [2:0]  day_cnt,
    output logic [1:0]  set_state
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_DAY  = 2'd3
    } state_e;

    localparam logic [27:0] CNT_LIM = 28'(CNT_MAX);

    state_e      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hour_q, hour_d;
    logic [2:0]  day_q, day_d;
    logic        mode_p, up_p;

    time_keeper_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_mode),
        .press_p (mode_p)
    );

    time_keeper_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .press_p (up_p)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        case (state_q)
            RUN: begin
                if (cnt_q == CNT_LIM) begin
                    cnt_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hour_q == 5'd23) begin
                                hour_d = '0;
                                day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
                if (mode_p) begin
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (mode_p) begin
                    state_d = SET_MIN;
                end else if (up_p) begin
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end
            end
            SET_MIN: begin
                if (mode_p) begin
                    state_d = SET_DAY;
                end else if (up_p) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            SET_DAY: begin
                if (mode_p) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    sec_d   = '0;
                end else if (up_p) begin
                    day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
        end
    end

    assign cnt       = cnt_q;
    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign day_cnt   = day_q;
    assign set_state = state_q;
endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: stimulus pushes model snapshots due at a
// given cycle, a negedge monitor pops and compares them against the outputs.

module tb_time_keeper;
    localparam int CM  = 9;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic [27:0] cnt;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [2:0]  day_cnt;
    logic [1:0]  set_state;

    time_keeper #(.CNT_MAX(CM), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .cnt       (cnt),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day_cnt   (day_cnt),
        .set_state (set_state)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int    due;
        string name;
        int    cnt, sec, min, hour, day, st;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: wall-clock time kept as plain integers, advanced arithmetically.
    int m_cnt, m_sec, m_min, m_hour, m_day, m_st, m_cyc;

    function automatic void chk(bit ok, string name, int got, int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, want);
    endfunction

    function automatic void m_reset();
        m_cnt = 0; m_sec = 0; m_min = 0; m_hour = 0; m_day = 0; m_st = 0; m_cyc = 0;
    endfunction

    function automatic void m_adv(int c);
        int total, ticks, s;
        if (m_st == 0 && c > m_cyc) begin
            total = m_cnt + (c - m_cyc);
            ticks = total / (CM + 1);
            m_cnt = total % (CM + 1);
            s = ((m_day * 24 + m_hour) * 60 + m_min) * 60 + m_sec + ticks;
            s = s % (7 * 86400);
            m_day = s / 86400;  s = s % 86400;
            m_hour = s / 3600;  s = s % 3600;
            m_min = s / 60;
            m_sec = s % 60;
        end
        m_cyc = c;
    endfunction

    function automatic void m_mode(int t);
        m_adv(t);
        if (m_st == 3) begin
            m_st = 0; m_cnt = 0; m_sec = 0;
        end else begin
            m_st++;
        end
    endfunction

    function automatic void m_up();
        case (m_st)
            1: m_hour = (m_hour + 1) % 24;
            2: m_min  = (m_min + 1) % 60;
            3: m_day  = (m_day + 1) % 7;
            default: ;
        endcase
    endfunction

    task automatic expect_at(int c, string name);
        exp_t e;
        m_adv(c);
        e.due = c; e.name = name;
        e.cnt = m_cnt; e.sec = m_sec; e.min = m_min;
        e.hour = m_hour; e.day = m_day; e.st = m_st;
        q.push_back(e);
    endtask

    task automatic check_at(int c, string name);
        expect_at(c, name);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_next(string name);
        check_at(cyc + 1, name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_checks++;
            $display("FAIL %s: deadline cycle %0d passed, now cycle %0d", e.name, e.due, cyc);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            n_checks++;
            if (int'(cnt) == e.cnt && int'(sec) == e.sec && int'(min) == e.min &&
                int'(hour) == e.hour && int'(day_cnt) == e.day && int'(set_state) == e.st)
                n_pass++;
            else
                $display("FAIL %s @%0d: got cnt=%0d sec=%0d min=%0d hour=%0d day=%0d st=%0d, required cnt=%0d sec=%0d min=%0d hour=%0d day=%0d st=%0d",
                         e.name, cyc, cnt, sec, min, hour, day_cnt, set_state,
                         e.cnt, e.sec, e.min, e.hour, e.day, e.st);
        end
    end

    task automatic up_press(int hold);
        btn_up = 1'b1;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        m_adv(cyc);
        m_up();
    endtask

    task automatic ups(int n);
        for (int i = 0; i < n; i++) up_press($urandom_range(5, 9));
    endtask

    // Raises mode (optionally with up, optionally after short bounces), then
    // expects exactly one state step within the allowed press latency.
    task automatic mode_press(int hold, bit bounce, bit with_up, output int t);
        int r, n_chg;
        logic [1:0] prev;
        if (bounce) begin
            repeat (2) begin
                btn_mode = 1'b1; repeat (2) @(negedge clk);
                btn_mode = 1'b0; repeat (2) @(negedge clk);
            end
        end
        prev = set_state; n_chg = 0; t = -1;
        btn_mode = 1'b1;
        if (with_up) btn_up = 1'b1;
        r = cyc;
        for (int i = 1; i <= hold + 14; i++) begin
            @(negedge clk);
            if (i == hold) begin
                btn_mode = 1'b0;
                if (with_up) btn_up = 1'b0;
            end
            if (set_state !== prev) begin
                n_chg++;
                prev = set_state;
                if (t < 0) t = cyc;
            end
        end
        chk(n_chg == 1, "mode_single_step", n_chg, 1);
        if (t >= 0) begin
            chk((t - r) <= DEB + 4, "mode_latency", t - r, DEB + 4);
            m_mode(t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk(1'b0, "queue_drain", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_exit;
        m_reset();
        expect_at(0, "reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        check_at(1, "run_c1");
        check_at(9, "run_c9");
        check_at(10, "run_c10_first_tick");
        for (int i = 0; i < 3; i++) check_at(cyc + $urandom_range(1, 150), "run_random");
        check_at(600, "run_600_min1");

        btn_mode = 1'b1; repeat (3) @(negedge clk); btn_mode = 1'b0;
        repeat (15) @(negedge clk);
        check_next("glitch_ignored");
        up_press($urandom_range(5, 9));
        check_next("up_in_run_ignored");

        mode_press(10, 1'b1, 1'b0, t);
        check_next("bounced_mode_to_set_hour");
        ups(1);  check_next("hour_inc");
        ups(23); check_next("hour_wrap");
        ups(23); check_next("hour_23");

        mode_press(10, 1'b0, 1'b0, t);
        ups(59); check_next("min_59");
        ups(1);  check_next("min_wrap_no_carry");
        ups(59); check_next("min_59_again");

        mode_press(10, 1'b0, 1'b0, t);
        ups(7);  check_next("day_wrap");
        ups(6);  check_next("day_6");

        mode_press(10, 1'b0, 1'b0, t_exit);
        check_next("exit_clears_cnt_sec");
        check_at(t_exit + 599, "pre_rollover");
        check_at(t_exit + 600, "full_rollover");
        for (int i = 0; i < 4; i++) check_at(cyc + $urandom_range(1, 200), "run_random2");

        mode_press(10, 1'b0, 1'b0, t);
        ups((5 - m_hour + 24) % 24);
        check_next("hour_5");
        mode_press(10, 1'b0, 1'b1, t);
        check_next("both_pressed_mode_wins");
        mode_press(10, 1'b0, 1'b0, t);
        mode_press(10, 1'b0, 1'b0, t);
        check_next("four_modes_back_to_run");

        for (int i = 0; i < 3; i++) mode_press(10, 1'b0, 1'b0, t);
        btn_up = 1'b1;
        repeat (12) @(negedge clk);
        m_adv(cyc); m_up();
        check_next("up_held_in_set_day");
        drain();

        @(negedge clk);
        #2 reset = 1'b0;
        m_reset();
        expect_at(0, "reset_mid_op");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_at(5, "post_reset_run");
        repeat (10) @(negedge clk);
        mode_press(10, 1'b0, 1'b0, t);
        check_next("held_up_no_pulse");
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        check_next("up_release_no_pulse");
        up_press(6);
        check_next("up_repress");

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter CNT_MAX, default 5399999: terminal value of sub-second counter cnt; one time tick per CNT_MAX+1 clocks.
REQ-002 Parameter DEB_CYCLES, default 270000: clocks a synchronized button level must hold stable before acceptance.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_mode  input  1  raw asynchronous mode button, active-high.
REQ-006 btn_up  input  1  raw asynchronous increment button, active-high.
REQ-007 cnt  output  28  sub-second counter, 0..CNT_MAX.
REQ-008 sec  output  6  seconds, 0..59.
REQ-009 min  output  6  minutes, 0..59.
REQ-010 hour  output  5  hours, 24-hour format, 0..23.
REQ-011 day_cnt  output  3  day of week, 0=MON .. 6=SUN.
REQ-012 set_state  output  2  mode: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_DAY.

Function
REQ-013 Each button shall pass a 2-flop synchronizer, then a debouncer: stable level register updates only after DEB_CYCLES consecutive identical synchronized samples; any change restarts the count.
REQ-014 A debounced 0->1 transition shall produce exactly one 1-cycle press pulse (mode_p, up_p); holding a button shall produce no further pulses.
REQ-015 Press pulse shall occur at most DEB_CYCLES+4 clocks after a clean raw rising edge; bounces shorter than DEB_CYCLES shall produce no pulse.
REQ-016 FSM states RUN, SET_HOUR, SET_MIN, SET_DAY; mode_p advances RUN->SET_HOUR->SET_MIN->SET_DAY->RUN; no other transitions.
REQ-017 In RUN, cnt shall increment every clock and wrap CNT_MAX->0; the wrap cycle is the tick.
REQ-018 On tick: sec increments; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day_cnt; day_cnt 6->0; all carries resolve in the same clock.
REQ-019 In any SET state, cnt, sec, and all non-selected fields shall hold; no tick or carry occurs.
REQ-020 up_p in SET_HOUR/SET_MIN/SET_DAY shall increment hour/min/day_cnt respectively with wrap (23->0, 59->0, 6->0) and no carry into other fields; up_p in RUN is ignored.
REQ-021 On SET_DAY->RUN transition, cnt and sec shall be cleared to 0 in that clock; counting resumes next clock.
REQ-022 mode_p and up_p in the same cycle: mode_p applies, up_p is discarded.
REQ-023 set_state shall reflect the FSM state registered, updating the clock after mode_p.
REQ-024 All outputs registered; no combinational path from buttons to outputs.
REQ-025 Out-of-range field values (day_cnt=7, unused encodings) shall not occur; default FSM branch returns to RUN.

Reset
REQ-026 reset low shall asynchronously force cnt=0, sec=0, min=0, hour=0, day_cnt=0, set_state=0 (RUN), synchronizers, debounce counters and stable levels to 0.
REQ-027 Reset asserted mid-operation (any state, during button hold) shall apply REQ-026 immediately; after release a still-held button shall produce no pulse until released and pressed again.
REQ-028 First tick after reset release shall occur CNT_MAX+1 clocks after the first active clock edge.

Verification (CNT_MAX=9, DEB_CYCLES=4 override)
REQ-029 Reset release, no buttons, 600 clocks -> sec=0 at clock 9, sec=1 after 10 clocks, min=1,sec=0 after 600 clocks; cnt sawtooth 0..9.
REQ-030 Preload via set mode to hour=23,min=59,day_cnt=6, run to sec=59,cnt=9 -> next clock hour=0,min=0,sec=0,day_cnt=0.
REQ-031 btn_mode pulse with 2-clock bounce glitches then held 10 clocks -> exactly one mode_p, set_state 0->1; glitch of 3 clocks alone -> no change.
REQ-032 In SET_MIN with min=59, one up press -> min=0, hour unchanged; in RUN, up press -> no field change; four mode presses from RUN -> back to RUN with cnt=0,sec=0.
REQ-033 Both buttons pressed simultaneously in SET_HOUR, hour=5 -> set_state=2, hour remains 5.
REQ-034 Assert reset while in SET_DAY with btn_up held, release with btn_up still held -> all outputs 0, set_state=0, no up_p until btn_up released and re-pressed.
